// File: rtl/dlx_mem_pkg.sv
// dlx_mem_pkg: size encodings, FSM states and lane-position helpers (lane order set by DLX_MEM_BIG_ENDIAN_EN)
package dlx_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE, RESP} state_t;
  function automatic logic [4:0] byte_lsb(input logic [1:0] k);
`ifdef DLX_MEM_BIG_ENDIAN_EN
    return {~k, 3'b000};
`else
    return {k, 3'b000};
`endif
  endfunction
  function automatic logic [4:0] half_lsb(input logic h);
`ifdef DLX_MEM_BIG_ENDIAN_EN
    return {~h, 4'b0000};
`else
    return {h, 4'b0000};
`endif
  endfunction
endpackage

// File: rtl/dlx_mem_access_unit_lane.sv
// dlx_mem_lane: load lane extract/extend and store lane merge; lane order from DLX_MEM_BIG_ENDIAN_EN
module dlx_mem_lane
  import dlx_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0]  b_sh, h_sh;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  always_comb begin
    b_sh   = byte_lsb(off);
    h_sh   = half_lsb(off[1]);
    rbyte  = 8'(old_word >> b_sh);
    rhalf  = 16'(old_word >> h_sh);
    rdata  = size == SZ_BYTE ? {{24{sgn & rbyte[7]}}, rbyte} :
             size == SZ_HALF ? {{16{sgn & rhalf[15]}}, rhalf} : old_word;
    merged = size == SZ_BYTE ? (old_word & ~(32'h0000_00ff << b_sh)) | ({24'b0, wdata[7:0]} << b_sh) :
             size == SZ_HALF ? (old_word & ~(32'h0000_ffff << h_sh)) | ({16'b0, wdata[15:0]} << h_sh) : wdata;
  end
endmodule

// File: rtl/dlx_mem_access_unit.sv
// dlx_mem_access_unit: DLX MEM-stage load/store front-end to a word RAM with read-modify-write sub-word stores
// Build option: DLX_MEM_BIG_ENDIAN_EN selects big-endian lane order (timing unchanged).
module dlx_mem_access_unit
  import dlx_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] ram_adr_o,
  output logic        ram_we_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);
  state_t      state;
  logic        r_we, r_signed, r_err, req_err;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_rdata, r_wr, rdata_ext, merged;
  assign req_err = (req_size_i == SZ_ILL) | (req_size_i == SZ_HALF & req_addr_i[0]) |
                   (req_size_i == SZ_WORD & |req_addr_i[1:0]) | (req_addr_i[31:2] >= 30'(DEPTH_WORDS));
  assign req_ready_o = reset_n & (state == IDLE);
  assign rsp_valid_o = state == RESP;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign ram_adr_o   = {2'b00, r_addr[31:2]};
  assign ram_we_o    = state == WR_ISSUE;
  assign ram_data_o  = r_wr;
  dlx_mem_lane u_lane (
    .size(r_size), .sgn(r_signed), .off(r_addr[1:0]), .old_word(ram_data_i),
    .wdata(r_wr), .rdata(rdata_ext), .merged(merged)
  );
  // r_wr carries the raw store data until the RMW merge replaces it with the full word
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      r_we     <= 1'b0;
      r_signed <= 1'b0;
      r_size   <= SZ_BYTE;
      r_addr   <= '0;
      r_wr     <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          r_we     <= req_we_i;
          r_size   <= req_size_i;
          r_signed <= req_signed_i;
          r_addr   <= req_addr_i;
          r_wr     <= req_wdata_i;
          r_rdata  <= '0;
          r_err    <= req_err;
          state    <= req_err ? RESP : (req_we_i & req_size_i == SZ_WORD) ? WR_ISSUE : RD_ISSUE;
        end
        RD_ISSUE: state <= RD_CAPTURE;
        RD_CAPTURE: begin
          if (r_we) r_wr <= merged;
          else r_rdata <= rdata_ext;
          state <= r_we ? WR_ISSUE : RESP;
        end
        WR_ISSUE: state <= RESP;
        RESP: if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dlx_mem_access_unit.sv
// tb_dlx_mem_access_unit: directed self-checking bench with a registered-read word RAM model
module tb_dlx_mem_access_unit;
  logic        clk_i = 0, reset_n = 0;
  logic        req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] rsp_rdata, ram_adr, ram_wdata, ram_rdata;
  logic        ram_we;
  logic [31:0] mem [64];
  int          n_checks = 0, n_fail = 0, we_cnt = 0;
  logic [31:0] last_we_adr = 0;
`ifdef DLX_MEM_BIG_ENDIAN_EN
  localparam logic [31:0] BYTE_EXP = 32'h0080_0000, HALF_EXP = 32'hAABB_1234, HALF0_EXP = 32'hFFFF_AABB;
`else
  localparam logic [31:0] BYTE_EXP = 32'h0000_8000, HALF_EXP = 32'h1234_CCDD, HALF0_EXP = 32'hFFFF_CCDD;
`endif

  always #5 clk_i = ~clk_i;

  dlx_mem_access_unit #(.DEPTH_WORDS(64)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .ram_adr_o(ram_adr), .ram_we_o(ram_we),
    .ram_data_o(ram_wdata), .ram_data_i(ram_rdata)
  );

  always @(posedge clk_i) begin
    if (ram_we) mem[ram_adr[5:0]] <= ram_wdata;
    ram_rdata <= mem[ram_adr[5:0]];
  end

  always @(posedge clk_i) if (ram_we) begin
    we_cnt = we_cnt + 1;
    last_we_adr = ram_adr;
  end

  task automatic xact(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk_i);
    req_valid = 1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk_i); #1 req_valid = 0;
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!rsp_valid && lat < 20);
    rd = rsp_rdata; e = rsp_err;
    rsp_ready = 1;
    @(posedge clk_i); #1 rsp_ready = 0;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0 || ram_we !== 1'b0 || rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got valid=%b we=%b err=%b want 0", rsp_valid, ram_we, rsp_err); end
    n_checks++; if (ram_adr !== 32'h0 || rsp_rdata !== 32'h0 || ram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got adr=%h rdata=%h wdata=%h want 0", ram_adr, rsp_rdata, ram_wdata); end
    @(negedge clk_i); reset_n = 1; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic e; int lat, c0;
    c0 = we_cnt;
    xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, e, lat);
    n_checks++; if (lat !== 2 || e !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL word_store_rsp: got lat=%0d err=%b rdata=%h want 2 0 0", lat, e, rd); end
    n_checks++; if (we_cnt - c0 !== 1 || last_we_adr !== 32'h4) begin n_fail++; $display("FAIL word_store_we: got pulses=%0d adr=%h want 1 4", we_cnt - c0, last_we_adr); end
    xact(0, 2'b10, 0, 32'h10, 32'h0, rd, e, lat);
    n_checks++; if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_load: got lat=%0d err=%b rdata=%h want 3 0 deadbeef", lat, e, rd); end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic e; int lat, c0;
    xact(1, 2'b10, 0, 32'h10, 32'h0, rd, e, lat);
    c0 = we_cnt;
    xact(1, 2'b00, 0, 32'h11, 32'hFFFF_FF80, rd, e, lat);
    n_checks++; if (lat !== 4 || e !== 1'b0 || we_cnt - c0 !== 1) begin n_fail++; $display("FAIL byte_store: got lat=%0d err=%b pulses=%0d want 4 0 1", lat, e, we_cnt - c0); end
    xact(0, 2'b00, 1, 32'h11, 32'h0, rd, e, lat);
    n_checks++; if (rd !== 32'hFFFF_FF80 || lat !== 3) begin n_fail++; $display("FAIL byte_load_signed: got %h lat=%0d want ffffff80 3", rd, lat); end
    xact(0, 2'b00, 0, 32'h11, 32'h0, rd, e, lat);
    n_checks++; if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_load_unsigned: got %h want 00000080", rd); end
    xact(0, 2'b10, 0, 32'h10, 32'h0, rd, e, lat);
    n_checks++; if (rd !== BYTE_EXP) begin n_fail++; $display("FAIL byte_ram_word: got %h want %h", rd, BYTE_EXP); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic e; int lat;
    xact(1, 2'b10, 0, 32'h10, 32'hAABBCCDD, rd, e, lat);
    xact(1, 2'b01, 0, 32'h12, 32'h0000_1234, rd, e, lat);
    n_checks++; if (lat !== 4 || e !== 1'b0) begin n_fail++; $display("FAIL half_store: got lat=%0d err=%b want 4 0", lat, e); end
    xact(0, 2'b10, 0, 32'h10, 32'h0, rd, e, lat);
    n_checks++; if (rd !== HALF_EXP) begin n_fail++; $display("FAIL half_ram_word: got %h want %h", rd, HALF_EXP); end
    xact(0, 2'b01, 1, 32'h12, 32'h0, rd, e, lat);
    n_checks++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL half_load_hi: got %h want 00001234", rd); end
    xact(0, 2'b01, 1, 32'h10, 32'h0, rd, e, lat);
    n_checks++; if (rd !== HALF0_EXP) begin n_fail++; $display("FAIL half_load_lo_signed: got %h want %h", rd, HALF0_EXP); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic e; int lat, c0;
    logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b10};
    logic        we [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] ad [5] = '{32'h6, 32'h3, 32'h100, 32'h0, 32'h100};
    for (int i = 0; i < 5; i++) begin
      c0 = we_cnt;
      xact(we[i], sz[i], 1, ad[i], 32'hFFFF_FFFF, rd, e, lat);
      n_checks++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 1 || we_cnt !== c0) begin n_fail++; $display("FAIL err_case%0d: got err=%b rdata=%h lat=%0d pulses=%0d want 1 0 1 0", i, e, rd, lat, we_cnt - c0); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk_i);
    req_valid = 1; req_we = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h10;
    @(posedge clk_i); #1 req_valid = 0;
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!rsp_valid && lat < 20);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== HALF_EXP || req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_cycle%0d: got valid=%b rdata=%h ready=%b want 1 %h 0", i, rsp_valid, rsp_rdata, req_ready, HALF_EXP); end
      @(negedge clk_i);
    end
    rsp_ready = 1;
    @(posedge clk_i); #1 rsp_ready = 0;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid;
    int n, c0;
    @(negedge clk_i);
    req_valid = 1; req_we = 1; req_size = 2'b00; req_signed = 0; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk_i); #1 req_valid = 0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!ram_we && n < 10);
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL mid_wr_issue_cycle: got %0d want 3", n); end
    c0 = we_cnt;
    reset_n = 0; #1;
    n_checks++; if (ram_we !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset: got we=%b valid=%b ready=%b want 0 0 0", ram_we, rsp_valid, req_ready); end
    #2 reset_n = 1; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_release_ready: got %b want 1", req_ready); end
    @(posedge clk_i); #1;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || we_cnt !== c0) begin n_fail++; $display("FAIL mid_after: got valid=%b ready=%b pulses=%0d want 0 1 0", rsp_valid, req_ready, we_cnt - c0); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_errors;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
